// File: rtl/interrupt_controller.sv
// interrupt_controller
// Synchronises NUM_SRC asynchronous board inputs, latches per-source events
// (edge or level mode), gates them with an enable mask and presents the
// lowest-index eligible source to the core via a req/ack/done handshake.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no request outstanding; arbitrates eligible sources each cycle
// REQUEST  | Int_Req high, Int_Id frozen until the core acknowledges
// SERVICE  | core is running the handler; waits for Int_Done, no nesting
module interrupt_controller #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic [NUM_SRC-1:0] Src_In,
  input  logic               Mask_Write,
  input  logic [NUM_SRC-1:0] Mask_Data,
  input  logic               Mode_Write,
  input  logic [NUM_SRC-1:0] Mode_Data,
  input  logic [NUM_SRC-1:0] Pend_Clear,
  input  logic               Int_Ack,
  input  logic               Int_Done,
  output logic               Int_Req,
  output logic [ID_W-1:0]    Int_Id,
  output logic               In_Service,
  output logic [NUM_SRC-1:0] Pending
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQUEST = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [1:0]         state_q, state_d;
  logic               req_q, req_d;
  logic               svc_q, svc_d;
  logic [ID_W-1:0]    id_q, id_d;

  logic               ack_fire;
  logic [NUM_SRC-1:0] ack_vec;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] edge_next;
  logic [NUM_SRC-1:0] mode_chg;
  logic [NUM_SRC-1:0] eligible;
  logic               any_elig;
  logic [ID_W-1:0]    win_id;

  // Configuration registers: writes land on the edge where they are sampled.
  always_comb begin
    mask_d = Mask_Write ? Mask_Data : mask_q;
    mode_d = Mode_Write ? Mode_Data : mode_q;
  end

  // Pending update. Edge bits: set beats clear. Level bits follow sync2.
  // A mode change wipes the affected bit so stale state never crosses modes.
  always_comb begin
    ack_fire = (state_q == ST_REQUEST) && Int_Ack;
    ack_vec  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_q == ID_W'(i)) ack_vec[i] = ack_fire;
    end
    rise      = sync2_q & ~prev_q;
    edge_next = (pend_q & ~(Pend_Clear | ack_vec)) | rise;
    mode_chg  = Mode_Write ? (mode_q ^ Mode_Data) : '0;
    pend_d    = ((mode_q & edge_next) | (~mode_q & sync2_q)) & ~mode_chg;
  end

  // Fixed priority: lowest eligible index wins.
  always_comb begin
    eligible = pend_q & mask_q;
    any_elig = |eligible;
    win_id   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  // Handshake FSM; Int_Id only changes when a new request is launched.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    svc_d   = svc_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          id_d    = win_id;
          req_d   = 1'b1;
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (Int_Ack) begin
          req_d   = 1'b0;
          svc_d   = 1'b1;
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (Int_Done) begin
          svc_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        // Unused encoding: recover to a quiet idle.
        req_d   = 1'b0;
        svc_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state registers, synchronous active-high clear.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '1;
      pend_q  <= '0;
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      svc_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      sync1_q <= Src_In;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      req_q   <= req_d;
      svc_q   <= svc_d;
      id_q    <= id_d;
    end
  end

  assign Int_Req    = req_q;
  assign Int_Id     = id_q;
  assign In_Service = svc_q;
  assign Pending    = pend_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller: directed handshake scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_interrupt_controller;

  localparam int N = 8;

  logic         CLK = 1'b0;
  logic         CLR;
  logic [N-1:0] Src_In;
  logic         Mask_Write;
  logic [N-1:0] Mask_Data;
  logic         Mode_Write;
  logic [N-1:0] Mode_Data;
  logic [N-1:0] Pend_Clear;
  logic         Int_Ack;
  logic         Int_Done;
  logic         Int_Req;
  logic [2:0]   Int_Id;
  logic         In_Service;
  logic [N-1:0] Pending;

  int errors = 0;
  int checks = 0;

  interrupt_controller #(.NUM_SRC(N), .ID_W(3)) dut (
    .CLK(CLK), .CLR(CLR), .Src_In(Src_In),
    .Mask_Write(Mask_Write), .Mask_Data(Mask_Data),
    .Mode_Write(Mode_Write), .Mode_Data(Mode_Data),
    .Pend_Clear(Pend_Clear), .Int_Ack(Int_Ack), .Int_Done(Int_Done),
    .Int_Req(Int_Req), .Int_Id(Int_Id), .In_Service(In_Service),
    .Pending(Pending)
  );

  always #5 CLK = ~CLK;

  // Behavioural model. h1/h2/h3 are Src_In as seen 1, 2 and 3 edges ago;
  // phase 0/1/2 = idle / requesting / servicing.
  logic [N-1:0] h1, h2, h3, m_pend, m_mask, m_mode, np;
  int           m_phase, m_id;
  logic         m_req, m_svc;

  always @(posedge CLK) begin
    if (CLR) begin
      h1 = '0; h2 = '0; h3 = '0;
      m_pend = '0; m_mask = '0; m_mode = '1;
      m_phase = 0; m_id = 0; m_req = 0; m_svc = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_mode[i]) begin
          np[i] = m_pend[i];
          if (Pend_Clear[i]) np[i] = 1'b0;
          if (m_phase == 1 && Int_Ack && m_id == i) np[i] = 1'b0;
          if (h2[i] && !h3[i]) np[i] = 1'b1;
        end else begin
          np[i] = h2[i];
        end
        if (Mode_Write && (Mode_Data[i] != m_mode[i])) np[i] = 1'b0;
      end
      if (m_phase == 0) begin
        for (int i = N - 1; i >= 0; i--) begin
          if (m_pend[i] && m_mask[i]) begin
            m_id = i; m_req = 1; m_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (Int_Ack) begin m_req = 0; m_svc = 1; m_phase = 2; end
      end else begin
        if (Int_Done) begin m_svc = 0; m_phase = 0; end
      end
      m_pend = np;
      if (Mask_Write) m_mask = Mask_Data;
      if (Mode_Write) m_mode = Mode_Data;
      h3 = h2; h2 = h1; h1 = Src_In;
    end
  end

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) @(negedge CLK);
  endtask

  task automatic test_reset();
    CLR = 1; Src_In = 8'hFF;
    cyc(2);
    checks++; if (Int_Req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", Int_Req); end
    checks++; if (In_Service !== 1'b0) begin errors++; $display("FAIL reset_svc got=%b exp=0", In_Service); end
    checks++; if (Int_Id !== 3'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", Int_Id); end
    checks++; if (Pending !== 8'h00) begin errors++; $display("FAIL reset_pend got=%h exp=00", Pending); end
    CLR = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      checks++; if (Int_Req !== 1'b0) begin errors++; $display("FAIL masked_req cyc=%0d got=%b exp=0", k, Int_Req); end
    end
    checks++; if (Pending !== 8'hFF) begin errors++; $display("FAIL reset_edge_pend got=%h exp=ff", Pending); end
    Src_In = 0; cyc(4);
    Pend_Clear = 8'hFF; cyc(); Pend_Clear = 0;
    checks++; if (Pending !== 8'h00) begin errors++; $display("FAIL pend_clear_all got=%h exp=00", Pending); end
  endtask

  task automatic test_edge();
    Mask_Write = 1; Mask_Data = 8'hFF; cyc(); Mask_Write = 0;
    Src_In = 8'h20;
    cyc(3);
    checks++; if (Pending !== 8'h20) begin errors++; $display("FAIL edge_pend got=%h exp=20", Pending); end
    checks++; if (Int_Req !== 1'b0) begin errors++; $display("FAIL edge_req_early got=%b exp=0", Int_Req); end
    Src_In = 0;
    cyc();
    checks++; if (Int_Req !== 1'b1 || Int_Id !== 3'd5) begin errors++; $display("FAIL edge_req got=%b/%0d exp=1/5", Int_Req, Int_Id); end
    Int_Ack = 1; cyc(); Int_Ack = 0;
    checks++; if (Int_Req !== 1'b0 || In_Service !== 1'b1 || Pending !== 8'h00) begin
      errors++; $display("FAIL edge_ack got req=%b svc=%b pend=%h exp 0/1/00", Int_Req, In_Service, Pending); end
    Int_Done = 1; cyc(); Int_Done = 0;
    checks++; if (In_Service !== 1'b0) begin errors++; $display("FAIL edge_done got=%b exp=0", In_Service); end
    cyc();
    checks++; if (Int_Req !== 1'b0) begin errors++; $display("FAIL edge_no_rereq got=%b exp=0", Int_Req); end
  endtask

  task automatic test_priority();
    Src_In = 8'h20; cyc(4);
    checks++; if (Int_Req !== 1'b1 || Int_Id !== 3'd5) begin errors++; $display("FAIL prio_req5 got=%b/%0d exp=1/5", Int_Req, Int_Id); end
    Src_In = 8'h24; cyc(5);
    checks++; if (Int_Req !== 1'b1 || Int_Id !== 3'd5 || Pending !== 8'h24) begin
      errors++; $display("FAIL prio_hold got req=%b id=%0d pend=%h exp 1/5/24", Int_Req, Int_Id, Pending); end
    Int_Ack = 1; cyc(); Int_Ack = 0;
    checks++; if (In_Service !== 1'b1 || Pending !== 8'h04) begin errors++; $display("FAIL prio_ack got svc=%b pend=%h exp 1/04", In_Service, Pending); end
    Int_Done = 1; cyc(); Int_Done = 0;
    checks++; if (Int_Req !== 1'b0 || In_Service !== 1'b0) begin errors++; $display("FAIL prio_done got req=%b svc=%b exp 0/0", Int_Req, In_Service); end
    cyc();
    checks++; if (Int_Req !== 1'b1 || Int_Id !== 3'd2) begin errors++; $display("FAIL prio_next got=%b/%0d exp=1/2", Int_Req, Int_Id); end
    Int_Ack = 1; cyc(); Int_Ack = 0;
    Int_Done = 1; cyc(); Int_Done = 0;
    Src_In = 0; cyc(4);
    checks++; if (Pending !== 8'h00 || Int_Req !== 1'b0) begin errors++; $display("FAIL prio_quiet got pend=%h req=%b exp 00/0", Pending, Int_Req); end
  endtask

  task automatic test_level();
    Mode_Write = 1; Mode_Data = 8'hF7; cyc(); Mode_Write = 0;
    Src_In = 8'h08; cyc(4);
    checks++; if (Int_Req !== 1'b1 || Int_Id !== 3'd3 || Pending !== 8'h08) begin
      errors++; $display("FAIL lvl_req got req=%b id=%0d pend=%h exp 1/3/08", Int_Req, Int_Id, Pending); end
    Int_Ack = 1; cyc(); Int_Ack = 0;
    checks++; if (In_Service !== 1'b1 || Pending !== 8'h08) begin errors++; $display("FAIL lvl_ack got svc=%b pend=%h exp 1/08", In_Service, Pending); end
    Int_Done = 1; cyc(); Int_Done = 0;
    cyc();
    checks++; if (Int_Req !== 1'b1 || Int_Id !== 3'd3) begin errors++; $display("FAIL lvl_rereq got=%b/%0d exp=1/3", Int_Req, Int_Id); end
    Src_In = 0; cyc(2);
    checks++; if (Pending !== 8'h08) begin errors++; $display("FAIL lvl_drop_early got=%h exp=08", Pending); end
    cyc();
    checks++; if (Pending !== 8'h00 || Int_Req !== 1'b1) begin errors++; $display("FAIL lvl_drop got pend=%h req=%b exp 00/1", Pending, Int_Req); end
    Int_Ack = 1; cyc(); Int_Ack = 0;
    Int_Done = 1; cyc(); Int_Done = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++; if (Int_Req !== 1'b0) begin errors++; $display("FAIL lvl_no_req cyc=%0d got=%b exp=0", k, Int_Req); end
    end
    Mode_Write = 1; Mode_Data = 8'hFF; cyc(); Mode_Write = 0;
  endtask

  task automatic test_mask_setwins();
    Mask_Write = 1; Mask_Data = 8'h01; cyc(); Mask_Write = 0;
    Src_In = 8'h10; cyc(3);
    checks++; if (Pending !== 8'h10) begin errors++; $display("FAIL mask_pend got=%h exp=10", Pending); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (Int_Req !== 1'b0) begin errors++; $display("FAIL mask_req cyc=%0d got=%b exp=0", k, Int_Req); end
    end
    Src_In = 0; cyc(3);
    Src_In = 8'h10; cyc(2);
    Pend_Clear = 8'h10; cyc(); Pend_Clear = 0;
    checks++; if (Pending[4] !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", Pending[4]); end
    Pend_Clear = 8'h10; cyc(); Pend_Clear = 0;
    checks++; if (Pending !== 8'h00) begin errors++; $display("FAIL plain_clear got=%h exp=00", Pending); end
    Src_In = 0; cyc(3);
  endtask

  task automatic test_reset_mid();
    Mask_Write = 1; Mask_Data = 8'hFF; cyc(); Mask_Write = 0;
    Src_In = 8'h02; cyc(4);
    checks++; if (Int_Req !== 1'b1 || Int_Id !== 3'd1) begin errors++; $display("FAIL mid_req got=%b/%0d exp=1/1", Int_Req, Int_Id); end
    Int_Ack = 1; cyc(); Int_Ack = 0;
    checks++; if (In_Service !== 1'b1) begin errors++; $display("FAIL mid_svc got=%b exp=1", In_Service); end
    CLR = 1; cyc(); CLR = 0; Src_In = 0;
    checks++; if (In_Service !== 1'b0 || Int_Req !== 1'b0 || Pending !== 8'h00 || Int_Id !== 3'd0) begin
      errors++; $display("FAIL mid_reset got svc=%b req=%b pend=%h id=%0d exp 0/0/00/0", In_Service, Int_Req, Pending, Int_Id); end
    Mask_Write = 1; Mask_Data = 8'hFF; cyc(); Mask_Write = 0;
    Src_In = 8'h01; cyc(4);
    checks++; if (Int_Req !== 1'b1 || Int_Id !== 3'd0) begin errors++; $display("FAIL mid_idle_req got=%b/%0d exp=1/0", Int_Req, Int_Id); end
    Int_Ack = 1; cyc(); Int_Ack = 0;
    Int_Done = 1; cyc(); Int_Done = 0;
    Src_In = 0; cyc(3);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      checks++;
      if (Int_Req !== m_req || Int_Id !== 3'(m_id) || In_Service !== m_svc || Pending !== m_pend) begin
        errors++;
        $display("FAIL rand cyc=%0d got req=%b id=%0d svc=%b pend=%h exp req=%b id=%0d svc=%b pend=%h",
                 k, Int_Req, Int_Id, In_Service, Pending, m_req, m_id, m_svc, m_pend);
      end
      for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) Src_In[i] = ~Src_In[i];
      Pend_Clear = N'($urandom & $urandom & $urandom & $urandom);
      Int_Ack    = ($urandom_range(2) == 0);
      Int_Done   = ($urandom_range(3) == 0);
      Mask_Write = ($urandom_range(19) == 0);
      Mask_Data  = N'($urandom);
      Mode_Write = ($urandom_range(29) == 0);
      Mode_Data  = N'($urandom);
      CLR        = ($urandom_range(299) == 0);
      cyc();
    end
    CLR = 0; Pend_Clear = 0; Int_Ack = 0; Int_Done = 0; Mask_Write = 0; Mode_Write = 0;
  endtask

  initial begin
    CLR = 1; Src_In = 8'hFF; Mask_Write = 0; Mask_Data = 0; Mode_Write = 0;
    Mode_Data = 0; Pend_Clear = 0; Int_Ack = 0; Int_Done = 0;
    test_reset();
    test_edge();
    test_priority();
    test_level();
    test_mask_setwins();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Parametrised interrupt controller replacing the fixed four-switch/four-button interrupt register. It synchronises NUM_SRC asynchronous board inputs and latches per-source events in edge or level mode. Each source is gated by a software-written enable mask. The highest-priority enabled source is presented to the processor core through a request/acknowledge/done handshake. The block sits between the board I/O pins and the core's interrupt input, on the single core clock.

## Interface

Parameters:
- NUM_SRC, 8, number of interrupt sources; legal range 2..16.
- ID_W, 3, width of the source ID; must satisfy NUM_SRC <= 2**ID_W.

Ports:
- CLK  in  1  core clock; everything is sampled on the rising edge.
- CLR  in  1  reset; synchronous, active-high.
- Src_In  in  NUM_SRC  raw asynchronous source inputs (switches, buttons); bit i is source i.
- Mask_Write  in  1  when high, load Mask_Data into the enable mask.
- Mask_Data  in  NUM_SRC  enable bits; 1 = source may request.
- Mode_Write  in  1  when high, load Mode_Data into the mode register.
- Mode_Data  in  NUM_SRC  1 = rising-edge mode, 0 = level mode.
- Pend_Clear  in  NUM_SRC  one-cycle pulses that clear edge-mode pending bits.
- Int_Ack  in  1  core acknowledges the current request.
- Int_Done  in  1  core signals the end of its service routine.
- Int_Req  out  1  interrupt request to the core.
- Int_Id  out  ID_W  ID of the requested or in-service source.
- In_Service  out  1  high while a source is being serviced.
- Pending  out  NUM_SRC  raw pending vector; not masked.

## Operation

- Synchroniser: Src_In passes through two flops (sync1, sync2). A third flop (prev) holds the previous sync2 value.
- Pending bits:
  - Edge mode: bit i sets when sync2[i] & ~prev[i]. It clears on Pend_Clear[i], or on Int_Ack when Int_Id == i. If a set and a clear occur in the same cycle, set wins.
  - Level mode: bit i equals sync2[i] each cycle. Ack and Pend_Clear have no effect on it.
- Mode_Write clears every pending bit whose mode actually changes. Pending bits latch regardless of the mask.
- Eligible vector = Pending & mask. Priority is fixed: the lowest index wins.
- State machine, state register reset to IDLE:
  - IDLE: if any bit is eligible, latch the winner into Int_Id, assert Int_Req, go to REQUEST.
  - REQUEST: Int_Req and Int_Id are held stable. No retraction and no re-arbitration, even if the source drops or is masked. On Int_Ack, drop Int_Req, assert In_Service, clear the edge-mode pending bit of Int_Id, go to SERVICE.
  - SERVICE: no nesting, so new events only latch into Pending. On Int_Done, drop In_Service and go to IDLE. Int_Ack is ignored in this state.
  - Int_Done received in IDLE or REQUEST is ignored.
- Mask/mode writes and Pend_Clear are legal in any state. They never alter Int_Id or the state.
- Reset values: Int_Req=0, In_Service=0, Int_Id=0, Pending=0, mask=0 (all disabled), mode=all 1 (edge), all synchroniser flops=0.
- Reset mid-operation returns to IDLE in one cycle, dropping any request or service in progress.

## Timing

- Src_In rising just before edge k: sync1 captures at k, sync2 at k+1, pending bit visible after edge k+2. Int_Req is registered and rises after edge k+3.
- Each edge-mode event lasts at least 2 CLK cycles. Shorter pulses may be lost.
- Int_Ack sampled high at edge a: Int_Req=0 and In_Service=1 after edge a. The pending bit clears at edge a.
- Int_Done sampled at edge d: In_Service=0 after edge d. A new Int_Req can rise after edge d+1 at the earliest, because IDLE arbitration is registered.
- Mask_Write/Mode_Write take effect on the edge where they are sampled. Their effect appears in Int_Req from the following arbitration onward.
- Every output is a flop output; there is no combinational path from input to output.

## Test plan

- Reset: hold CLR for 2 cycles with Src_In=8'hFF -> all outputs 0. Mode reads all-edge and mask reads 0. Int_Req stays 0 for 10 cycles because every source is masked.
- Edge request/handshake: mask=8'hFF, pulse Src_In[5] high for 3 cycles -> Pending[5]=1 after 3 edges and Int_Req=1, Int_Id=5 one cycle later. Ack -> Pending[5]=0, In_Service=1. Done -> In_Service=0.
- Priority and hold: with Int_Req up for source 5, raise source 2 -> Int_Id stays 5 until ack. After Done, the next request carries Int_Id=2.
- Level mode: mode bit 3=0, hold Src_In[3]=1, ack and done -> a second request for ID 3 follows. Drop Src_In[3] -> Pending[3]=0 three cycles later and no further request.
- Masking and set-wins: mask=8'h01, assert Src_In[4] -> Pending[4]=1 and Int_Req=0. Pend_Clear[4] in the same cycle as a new Src_In[4] edge -> Pending[4] stays 1.
- Reset mid-service: CLR asserted while In_Service=1 -> In_Service=0, state IDLE, Pending=0 after one edge.
